step_dir_shaper: RTL and testbench

Turns the single-cycle step requests and direction bit from the coordinated-move DDA into STEP/DIR signals that driver ICs and the microstepper can accept. It enforces a programmable DIR setup time, a minimum STEP high time and a minimum STEP low time. It holds one pending request and flags any request lost to overrun. It also keeps a signed absolute position count. The block sits between the DDA step generator and the motor driver or microstepper step/dir inputs.

---
 rtl/step_dir_shaper.sv | 138 +++++++++++++
 tb/tb_step_dir_shaper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_shaper.sv
// step_dir_shaper: shapes single-cycle DDA step strobes into timed STEP/DIR driver signals
//
// Enforces a DIR-to-STEP setup time, a minimum STEP high time and a minimum
// STEP low time. Holds one pending request, flags requests lost to overrun and
// keeps a signed two's-complement position count.
//
// Ports:
//   CLK            system clock
//   resetn         synchronous active-low reset
//   enable         1 = operate, 0 = abort the current pulse and ignore requests
//   step_req       one-cycle step request strobe
//   dir_req        direction of the request (1 = positive)
//   dir_setup      DIR-to-STEP-rise delay in cycles (0 behaves as 1)
//   pulse_high     STEP high time in cycles (0 behaves as 1)
//   pulse_low      minimum STEP low time in cycles (0 behaves as 1)
//   position_clear synchronous clear of the position counter (wins over a step)
//   overrun_clear  clears the sticky overrun flag (a new drop wins)
//   STEP           registered step output
//   DIR            registered direction output
//   busy           a pulse sequence is in progress or a request is pending
//   overrun        sticky flag, set when a request is dropped
//   position       signed step count, wraps at POS_BITS
module step_dir_shaper #(
   parameter int POS_BITS  = 64,
   parameter int TIME_BITS = 16
) (
   input  logic                       CLK,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic                       step_req,
   input  logic                       dir_req,
   input  logic [TIME_BITS-1:0]       dir_setup,
   input  logic [TIME_BITS-1:0]       pulse_high,
   input  logic [TIME_BITS-1:0]       pulse_low,
   input  logic                       position_clear,
   input  logic                       overrun_clear,
   output logic                       STEP,
   output logic                       DIR,
   output logic                       busy,
   output logic                       overrun,
   output logic signed [POS_BITS-1:0] position
);
   typedef enum logic [1:0] {IDLE, DIR_SETUP, HIGH, LOW} state_t;

   localparam logic [TIME_BITS-1:0] T_ONE = TIME_BITS'(1);
   localparam logic [POS_BITS-1:0]  P_ONE = POS_BITS'(1);

   state_t                     state_q, state_d;
   logic [TIME_BITS-1:0]       cnt_q, cnt_d;
   logic                       step_q, step_d;
   logic                       dir_q, dir_d;
   logic                       slot_q, slot_d;
   logic                       slot_dir_q, slot_dir_d;
   logic                       ovr_q, ovr_d;
   logic signed [POS_BITS-1:0] pos_q, pos_d;
   logic                       cnt_done, low_done, start, start_dir, drop, inc;

   // Counter is loaded with length-1; a zero setting still gives a one-cycle phase.
   function automatic logic [TIME_BITS-1:0] len_m1(input logic [TIME_BITS-1:0] x);
      return (x == '0) ? '0 : x - T_ONE;
   endfunction

   always_comb begin
      cnt_done   = (cnt_q == '0);
      low_done   = (state_q == LOW) && cnt_done;
      // A request starts from IDLE, or as LOW finishes: the pending slot has
      // priority, otherwise a strobe arriving in that exit cycle starts directly.
      start      = enable && (((state_q == IDLE) && step_req) || (low_done && (slot_q || step_req)));
      start_dir  = (low_done && slot_q) ? slot_dir_q : dir_req;
      // A strobe meeting a full slot is lost, including in the cycle the slot is consumed.
      drop       = enable && step_req && slot_q;
      state_d    = state_q;
      cnt_d      = cnt_done ? cnt_q : cnt_q - T_ONE;
      dir_d      = dir_q;
      slot_d     = slot_q;
      slot_dir_d = slot_dir_q;
      if (start) begin
         slot_d = 1'b0;
         if (start_dir != dir_q) begin
            dir_d   = start_dir;
            state_d = DIR_SETUP;
            cnt_d   = len_m1(dir_setup);
         end else begin
            state_d = HIGH;
            cnt_d   = len_m1(pulse_high);
         end
      end else if (cnt_done) begin
         case (state_q)
            DIR_SETUP: begin state_d = HIGH; cnt_d = len_m1(pulse_high); end
            HIGH:      begin state_d = LOW;  cnt_d = len_m1(pulse_low);  end
            LOW:       state_d = IDLE;
            default:   state_d = state_q;
         endcase
      end
      if (enable && step_req && (state_q != IDLE) && !slot_q && !low_done) begin
         slot_d     = 1'b1;
         slot_dir_d = dir_req;
      end
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         slot_d  = 1'b0;
      end
      step_d = (state_d == HIGH);
      // Position counts on the edge STEP rises, using the direction already on DIR.
      inc    = (state_d == HIGH) && (state_q != HIGH);
      pos_d  = position_clear ? '0 : inc ? (dir_d ? pos_q + P_ONE : pos_q - P_ONE) : pos_q;
      ovr_d  = drop || (ovr_q && !overrun_clear);
   end

   always_ff @(posedge CLK) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         step_q     <= 1'b0;
         dir_q      <= 1'b0;
         slot_q     <= 1'b0;
         slot_dir_q <= 1'b0;
         ovr_q      <= 1'b0;
         pos_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         slot_q     <= slot_d;
         slot_dir_q <= slot_dir_d;
         ovr_q      <= ovr_d;
         pos_q      <= pos_d;
      end
   end

   assign STEP     = step_q;
   assign DIR      = dir_q;
   assign busy     = (state_q != IDLE) || slot_q;
   assign overrun  = ovr_q;
   assign position = pos_q;
endmodule

// File: tb/tb_step_dir_shaper.sv
// tb_step_dir_shaper: timestamp-based reference model, per-cycle compare, directed and random stimulus
module tb_step_dir_shaper;
   localparam int PB = 8;
   localparam int TB = 16;
   localparam longint INF = 64'h7fff_ffff_ffff_ffff;

   logic CLK = 0, resetn = 0, enable = 0, step_req = 0, dir_req = 0;
   logic position_clear = 0, overrun_clear = 0;
   logic [TB-1:0] dir_setup = 0, pulse_high = 0, pulse_low = 0;
   logic STEP, DIR, busy, overrun;
   logic [PB-1:0] position;

   int checks = 0, errors = 0, pulses = 0;
   bit cmp_on = 0, prev_step = 0;

   always #5 CLK = ~CLK;

   step_dir_shaper #(.POS_BITS(PB), .TIME_BITS(TB)) dut (
      .CLK(CLK), .resetn(resetn), .enable(enable), .step_req(step_req), .dir_req(dir_req),
      .dir_setup(dir_setup), .pulse_high(pulse_high), .pulse_low(pulse_low),
      .position_clear(position_clear), .overrun_clear(overrun_clear),
      .STEP(STEP), .DIR(DIR), .busy(busy), .overrun(overrun), .position(position)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: each operation is a set of edge timestamps.
   // r = edge STEP rises, hf = edge STEP falls, e = edge the low time ends.
   longint ek = 0, m_r = INF, m_hf = INF, m_e = INF;
   bit m_act = 0, m_pend = 0, m_pdir = 0, m_dir = 0, m_ovr = 0, m_step = 0;
   logic [PB-1:0] m_pos = 0;

   function automatic longint eff(input logic [TB-1:0] x);
      return (x == 0) ? 64'd1 : longint'(x);
   endfunction

   task automatic m_start(input bit d);
      if (d != m_dir) begin
         m_dir = d;
         m_r = ek + eff(dir_setup);
      end else m_r = ek;
      m_hf = INF;
      m_e = INF;
      m_act = 1;
   endtask

   always @(posedge CLK) begin
      bit drop;
      drop = 0;
      if (!resetn) begin
         m_act = 0; m_pend = 0; m_dir = 0; m_pos = 0; m_ovr = 0;
      end else begin
         if (!enable) begin
            m_act = 0; m_pend = 0;
         end else begin
            if (m_act && ek != m_e) begin
               if (step_req) begin
                  if (m_pend) drop = 1;
                  else begin m_pend = 1; m_pdir = dir_req; end
               end
            end else if (m_pend) begin
               m_start(m_pdir);
               m_pend = 0;
               if (step_req) drop = 1;
            end else if (step_req) m_start(dir_req);
            else m_act = 0;
            if (m_act && ek == m_r) begin
               m_pos = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
               m_hf = ek + eff(pulse_high);
            end
            if (m_act && ek == m_hf) m_e = ek + eff(pulse_low);
         end
         if (position_clear) m_pos = 0;
         m_ovr = drop ? 1'b1 : (overrun_clear ? 1'b0 : m_ovr);
      end
      m_step = m_act && ek >= m_r && ek < m_hf;
      ek++;
   end

   always @(negedge CLK) begin
      if (cmp_on) begin
         chk("STEP", STEP, m_step);
         chk("DIR", DIR, m_dir);
         chk("busy", busy, m_act || m_pend);
         chk("overrun", overrun, m_ovr);
         chk("position", position, m_pos);
         if (STEP === 1'b1 && !prev_step) pulses++;
         prev_step = (STEP === 1'b1);
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge CLK);
      chk("idle_wait", busy, 0);
   endtask

   task automatic req1(input bit d);
      step_req = 1; dir_req = d;
      @(negedge CLK);
      step_req = 0;
      @(negedge CLK);
   endtask

   initial begin
      int p0;
      logic [PB-1:0] pv;
      enable = 1;
      repeat (3) @(negedge CLK);
      cmp_on = 1;
      chk("rst_STEP", STEP, 0); chk("rst_DIR", DIR, 0); chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0); chk("rst_pos", position, 0);
      resetn = 1;
      @(negedge CLK);
      // same-direction step
      dir_setup = 3; pulse_high = 4; pulse_low = 2;
      step_req = 1; dir_req = 0;
      @(negedge CLK);
      step_req = 0;
      chk("t1_pos", position, 8'hFF); chk("t1_model_pos", m_pos, 8'hFF);
      for (int i = 1; i <= 6; i++) begin
         chk("t1_step", STEP, i <= 4);
         chk("t1_busy", busy, 1);
         @(negedge CLK);
      end
      chk("t1_idle", busy, 0); chk("t1_step_low", STEP, 0);
      // direction change
      step_req = 1; dir_req = 1;
      @(negedge CLK);
      step_req = 0;
      chk("t2_dir", DIR, 1);
      for (int i = 1; i <= 3; i++) begin
         chk("t2_setup", STEP, 0);
         @(negedge CLK);
      end
      chk("t2_rise", STEP, 1); chk("t2_pos", position, 0); chk("t2_model_pos", m_pos, 0);
      wait_idle();
      // overrun: three consecutive strobes
      p0 = pulses;
      step_req = 1; dir_req = 1;
      repeat (3) @(negedge CLK);
      step_req = 0;
      chk("t3_ovr", overrun, 1); chk("t3_model_ovr", m_ovr, 1);
      wait_idle();
      chk("t3_pulses", pulses - p0, 2);
      overrun_clear = 1;
      @(negedge CLK);
      overrun_clear = 0;
      chk("t3_ovr_clr", overrun, 0);
      // zero-length config, back-to-back
      dir_setup = 0; pulse_high = 0; pulse_low = 0;
      position_clear = 1;
      @(negedge CLK);
      position_clear = 0;
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         step_req = 1; dir_req = 1;
         @(negedge CLK);
         step_req = 0;
         chk("t4_high", STEP, 1);
         @(negedge CLK);
         chk("t4_low", STEP, 0);
      end
      wait_idle();
      chk("t4_pulses", pulses - p0, 10); chk("t4_pos", position, 10); chk("t4_ovr", overrun, 0);
      // enable dropped mid-HIGH with a pending request
      dir_setup = 3; pulse_high = 4; pulse_low = 2;
      step_req = 1; dir_req = 1;
      @(negedge CLK);
      pv = position;
      chk("t5_pos_counted", pv, 11);
      @(negedge CLK);
      step_req = 0;
      chk("t5_pending", busy, 1);
      enable = 0;
      @(negedge CLK);
      chk("t5_step_off", STEP, 0); chk("t5_busy_off", busy, 0); chk("t5_pos_hold", position, pv);
      step_req = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("t5_dis_step", STEP, 0); chk("t5_dis_busy", busy, 0);
      end
      step_req = 0; enable = 1;
      @(negedge CLK);
      chk("t5_no_restart", busy, 0); chk("t5_pos_final", position, pv);
      // wrap of the signed position
      dir_setup = 0; pulse_high = 0; pulse_low = 0;
      position_clear = 1;
      @(negedge CLK);
      position_clear = 0;
      for (int i = 0; i < 127; i++) req1(1);
      wait_idle();
      chk("t6_max", position, 8'h7F);
      req1(1);
      wait_idle();
      chk("t6_wrap", position, 8'h80);
      step_req = 1; dir_req = 1; position_clear = 1;
      @(negedge CLK);
      step_req = 0; position_clear = 0;
      chk("t6_clr_step", STEP, 1); chk("t6_clr_wins", position, 0);
      wait_idle();
      // randomized traffic with config changes, aborts and resets
      for (int i = 0; i < 4000; i++) begin
         step_req = ($urandom_range(0, 99) < 35);
         dir_req = 1'($urandom_range(0, 1));
         enable = ($urandom_range(0, 99) >= 2);
         position_clear = ($urandom_range(0, 99) < 1);
         overrun_clear = ($urandom_range(0, 99) < 3);
         resetn = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 49) == 0) begin
            dir_setup = TB'($urandom_range(0, 4));
            pulse_high = TB'($urandom_range(0, 4));
            pulse_low = TB'($urandom_range(0, 4));
         end
         @(negedge CLK);
      end
      resetn = 1; enable = 1; step_req = 0; position_clear = 0; overrun_clear = 0;
      wait_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
